// File: rtl/vga_plot_arbiter_if.sv
// Pixel-request and VGA adapter write-port bundle shared by game logic and vga_plot_arbiter.
interface vga_plot_arbiter_if #(
  parameter int unsigned NUM_REQ = 3
);
  logic                   clear_req;
  logic                   clear_busy;
  logic                   clear_done;
  logic [NUM_REQ-1:0]     req;
  logic [8*NUM_REQ-1:0]   req_x;
  logic [7*NUM_REQ-1:0]   req_y;
  logic [3*NUM_REQ-1:0]   req_colour;
  logic [NUM_REQ-1:0]     ack;
  logic [7:0]             vga_x;
  logic [6:0]             vga_y;
  logic [2:0]             vga_colour;
  logic                   vga_plot;

  modport slave (
    input  clear_req, req, req_x, req_y, req_colour,
    output clear_busy, clear_done, ack, vga_x, vga_y, vga_colour, vga_plot
  );

  modport master (
    output clear_req, req, req_x, req_y, req_colour,
    input  clear_busy, clear_done, ack, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Owns the VGA write port: full-screen clear sweep, then round-robin single-pixel grants.
// Optional macro VGA_PLOT_ARBITER_BORDER_EN paints the sweep's outer ring in BORDER_COLOUR.
module vga_plot_arbiter #(
  parameter int unsigned WIDTH         = 160,
  parameter int unsigned HEIGHT        = 120,
  parameter int unsigned NUM_REQ       = 3,
  parameter logic [2:0]  CLEAR_COLOUR  = 3'b000,
  parameter logic [2:0]  BORDER_COLOUR = 3'b111
) (
  input  logic              clk,
  input  logic              reset_n,
  vga_plot_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0]  X_MAX = 8'(WIDTH - 1);
  localparam logic [6:0]  Y_MAX = 7'(HEIGHT - 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_PLOT} state_t;

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_cnt_x, w_cnt_x_nxt;
  logic [6:0]         r_cnt_y, w_cnt_y_nxt;
  logic               r_sweep_end, w_sweep_end_nxt;
  logic               r_clear_pend, w_clear_pend_nxt;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [7:0]         r_vga_x, w_vga_x_nxt;
  logic [6:0]         r_vga_y, w_vga_y_nxt;
  logic [2:0]         r_vga_colour, w_vga_colour_nxt;
  logic               r_vga_plot, w_vga_plot_nxt;
  logic [NUM_REQ-1:0] r_ack, w_ack_nxt;
  logic               r_clear_busy, w_clear_busy_nxt;
  logic               r_clear_done, w_clear_done_nxt;

  logic [7:0]         w_rx [NUM_REQ];
  logic [6:0]         w_ry [NUM_REQ];
  logic [2:0]         w_rc [NUM_REQ];
  logic               w_any;
  logic [PTR_W-1:0]   w_win;
  logic [PTR_W-1:0]   w_idx;
  logic               w_in_range;
  logic [2:0]         w_sweep_colour;
  logic               w_clear_go;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign w_rx[i] = bus.req_x[8*i +: 8];
    assign w_ry[i] = bus.req_y[7*i +: 7];
    assign w_rc[i] = bus.req_colour[3*i +: 3];
  end

`ifdef VGA_PLOT_ARBITER_BORDER_EN
  assign w_sweep_colour = (r_cnt_x == 8'd0 || r_cnt_x == X_MAX ||
                           r_cnt_y == 7'd0 || r_cnt_y == Y_MAX) ? BORDER_COLOUR : CLEAR_COLOUR;
`else
  assign w_sweep_colour = CLEAR_COLOUR;
`endif

  assign w_clear_go = bus.clear_req | r_clear_pend;
  assign w_in_range = (32'(w_rx[w_win]) < WIDTH) && (32'(w_ry[w_win]) < HEIGHT);

  // Round-robin search starting just after the last winner
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      w_idx = PTR_W'((int'(r_ptr) + k) % int'(NUM_REQ));
      if (!w_any && bus.req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_CLEAR;
      r_cnt_x      <= '0;
      r_cnt_y      <= '0;
      r_sweep_end  <= 1'b0;
      r_clear_pend <= 1'b0;
      r_ptr        <= PTR_W'(NUM_REQ - 1);
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_vga_plot   <= 1'b0;
      r_ack        <= '0;
      r_clear_busy <= 1'b1;
      r_clear_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt_x      <= w_cnt_x_nxt;
      r_cnt_y      <= w_cnt_y_nxt;
      r_sweep_end  <= w_sweep_end_nxt;
      r_clear_pend <= w_clear_pend_nxt;
      r_ptr        <= w_ptr_nxt;
      r_vga_x      <= w_vga_x_nxt;
      r_vga_y      <= w_vga_y_nxt;
      r_vga_colour <= w_vga_colour_nxt;
      r_vga_plot   <= w_vga_plot_nxt;
      r_ack        <= w_ack_nxt;
      r_clear_busy <= w_clear_busy_nxt;
      r_clear_done <= w_clear_done_nxt;
    end
  end

  // Next-state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (r_sweep_end) w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (w_clear_go)  w_state_nxt = S_CLEAR;
        else if (w_any)  w_state_nxt = S_PLOT;
      end
      S_PLOT:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // Next values of outputs and datapath registers
  always_comb begin
    w_cnt_x_nxt      = r_cnt_x;
    w_cnt_y_nxt      = r_cnt_y;
    w_sweep_end_nxt  = r_sweep_end;
    w_clear_pend_nxt = r_clear_pend;
    w_ptr_nxt        = r_ptr;
    w_vga_x_nxt      = r_vga_x;
    w_vga_y_nxt      = r_vga_y;
    w_vga_colour_nxt = r_vga_colour;
    w_vga_plot_nxt   = 1'b0;
    w_ack_nxt        = '0;
    w_clear_busy_nxt = 1'b0;
    w_clear_done_nxt = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clear_pend_nxt = 1'b0;
        if (!r_sweep_end) begin
          w_clear_busy_nxt = 1'b1;
          w_vga_plot_nxt   = 1'b1;
          w_vga_x_nxt      = r_cnt_x;
          w_vga_y_nxt      = r_cnt_y;
          w_vga_colour_nxt = w_sweep_colour;
          if (r_cnt_x == X_MAX) begin
            w_cnt_x_nxt = '0;
            if (r_cnt_y == Y_MAX) begin
              w_cnt_y_nxt     = '0;
              w_sweep_end_nxt = 1'b1;
            end else begin
              w_cnt_y_nxt = r_cnt_y + 7'd1;
            end
          end else begin
            w_cnt_x_nxt = r_cnt_x + 8'd1;
          end
        end else begin
          w_sweep_end_nxt  = 1'b0;
          w_clear_done_nxt = 1'b1;
        end
      end
      S_IDLE: begin
        if (w_clear_go) begin
          w_clear_pend_nxt = 1'b0;
          w_clear_busy_nxt = 1'b1;
          w_cnt_x_nxt      = '0;
          w_cnt_y_nxt      = '0;
          w_sweep_end_nxt  = 1'b0;
        end else if (w_any) begin
          w_vga_x_nxt      = w_rx[w_win];
          w_vga_y_nxt      = w_ry[w_win];
          w_vga_colour_nxt = w_rc[w_win];
          w_vga_plot_nxt   = w_in_range;
          w_ack_nxt[w_win] = 1'b1;
          w_ptr_nxt        = w_win;
        end
      end
      S_PLOT: begin
        if (bus.clear_req) w_clear_pend_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.vga_x      = r_vga_x;
  assign bus.vga_y      = r_vga_y;
  assign bus.vga_colour = r_vga_colour;
  assign bus.vga_plot   = r_vga_plot;
  assign bus.ack        = r_ack;
  assign bus.clear_busy = r_clear_busy;
  assign bus.clear_done = r_clear_done;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter: stimulus queues expected write-port events, a monitor pops and compares.
module tb_vga_plot_arbiter;

  localparam int unsigned NR = 3;

  typedef struct {
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
    logic [2:0] ack;
    logic       done;
    logic       busy;
    int         gap;
  } exp_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  int   cyc;
  logic [NR-1:0] rereq;
  exp_t q[$];

  vga_plot_arbiter_if #(.NUM_REQ(NR)) bus ();

  vga_plot_arbiter #(.NUM_REQ(NR)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] sweep_col(input int x, input int y);
`ifdef VGA_PLOT_ARBITER_BORDER_EN
    return (x == 0 || x == 159 || y == 0 || y == 119) ? 3'd7 : 3'd0;
`else
    return 3'd0;
`endif
  endfunction

  task automatic push_ev(input logic plot, input int x, input int y, input logic [2:0] col,
                         input logic [2:0] ack, input logic done, input logic busy, input int gap);
    exp_t e;
    e.plot = plot; e.x = 8'(x); e.y = 7'(y); e.col = col;
    e.ack = ack; e.done = done; e.busy = busy; e.gap = gap;
    q.push_back(e);
  endtask

  // Queue the first n sweep pixels (optionally followed by clear_done)
  task automatic push_sweep(input int n, input bit with_done);
    for (int i = 0; i < n; i++)
      push_ev(1'b1, i % 160, i / 160, sweep_col(i % 160, i / 160), 3'b000, 1'b0, 1'b1, (i == 0) ? 0 : 1);
    if (with_done) push_ev(1'b0, 0, 0, 3'd0, 3'b000, 1'b1, 1'b0, 1);
  endtask

  task automatic set_req(input int i, input int x, input int y, input int c);
    bus.req_x[8*i +: 8]      = 8'(x);
    bus.req_y[7*i +: 7]      = 7'(y);
    bus.req_colour[3*i +: 3] = 3'(c);
    bus.req[i]               = 1'b1;
  endtask

  // One cycle of requester behaviour, acting just after the monitor's sample point
  task automatic tick();
    @(negedge clk);
    #1;
    for (int i = 0; i < int'(NR); i++)
      if (bus.ack[i] && !rereq[i]) bus.req[i] = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d events still pending, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic monitor();
    exp_t e;
    int   last;
    bit   ok;
    last = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        checks++;
        if (bus.vga_plot || bus.vga_x != 8'd0 || bus.vga_y != 7'd0 || bus.vga_colour != 3'd0 ||
            bus.ack != '0 || bus.clear_done || !bus.clear_busy) begin
          failures++;
          $display("FAIL reset_values: plot=%0b x=%0d y=%0d col=%0d ack=%b done=%0b busy=%0b, required all 0 with busy=1",
                   bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour, bus.ack, bus.clear_done, bus.clear_busy);
        end
      end else if (bus.vga_plot || bus.ack != '0 || bus.clear_done) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event: plot=%0b x=%0d y=%0d ack=%b done=%0b, required no event",
                   bus.vga_plot, bus.vga_x, bus.vga_y, bus.ack, bus.clear_done);
        end else begin
          e  = q.pop_front();
          ok = (bus.vga_plot == e.plot) && (bus.ack == e.ack) && (bus.clear_done == e.done) &&
               (bus.clear_busy == e.busy) && (e.gap == 0 || cyc - last == e.gap) &&
               (!e.plot || (bus.vga_x == e.x && bus.vga_y == e.y && bus.vga_colour == e.col));
          if (!ok) begin
            failures++;
            $display("FAIL event: got plot=%0b x=%0d y=%0d col=%0d ack=%b done=%0b busy=%0b gap=%0d, required plot=%0b x=%0d y=%0d col=%0d ack=%b done=%0b busy=%0b gap=%0d",
                     bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour, bus.ack, bus.clear_done,
                     bus.clear_busy, cyc - last, e.plot, e.x, e.y, e.col, e.ack, e.done, e.busy, e.gap);
          end
        end
        last = cyc;
      end
    end
  endtask

  initial begin
    int n;
    checks = 0; failures = 0; cyc = 0; rereq = '0;
    reset_n = 1'b0;
    bus.clear_req = 1'b0; bus.req = '0;
    bus.req_x = '0; bus.req_y = '0; bus.req_colour = '0;
    fork monitor(); join_none

    // Power-up sweep
    push_sweep(19200, 1'b1);
    repeat (3) tick();
    reset_n = 1'b1;
    wait_drain(19300);
    repeat (4) tick();

    // All three request at once, each dropping on its ack
    set_req(0, 10, 20, 1);
    set_req(1, 20, 30, 2);
    set_req(2, 159, 119, 5);
    push_ev(1'b1, 10, 20, 3'd1, 3'b001, 1'b0, 1'b0, 0);
    push_ev(1'b1, 20, 30, 3'd2, 3'b010, 1'b0, 1'b0, 2);
    push_ev(1'b1, 159, 119, 3'd5, 3'b100, 1'b0, 1'b0, 2);
    wait_drain(20);
    repeat (4) tick();

    // Two continuous requesters must alternate
    rereq = 3'b110;
    push_ev(1'b1, 20, 30, 3'd2, 3'b010, 1'b0, 1'b0, 0);
    push_ev(1'b1, 159, 119, 3'd5, 3'b100, 1'b0, 1'b0, 2);
    push_ev(1'b1, 20, 30, 3'd2, 3'b010, 1'b0, 1'b0, 2);
    push_ev(1'b1, 159, 119, 3'd5, 3'b100, 1'b0, 1'b0, 2);
    set_req(1, 20, 30, 2);
    set_req(2, 159, 119, 5);
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      tick();
      if (bus.ack != '0) n++;
    end
    bus.req = '0;
    rereq = '0;
    wait_drain(10);
    repeat (4) tick();

    // Out-of-range x: acknowledged but not written
    push_ev(1'b0, 0, 0, 3'd0, 3'b001, 1'b0, 1'b0, 0);
    set_req(0, 160, 5, 3);
    wait_drain(10);
    repeat (4) tick();

    // clear_req beats a simultaneous pixel request; mid-sweep clear_req is ignored
    push_sweep(19200, 1'b1);
    push_ev(1'b1, 1, 2, 3'd3, 3'b001, 1'b0, 1'b0, 1);
    bus.clear_req = 1'b1;
    set_req(0, 1, 2, 3);
    tick();
    bus.clear_req = 1'b0;
    repeat (5000) tick();
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    wait_drain(19300);
    repeat (4) tick();

    // Reset mid-sweep at pixel (50,30), then a full restarted sweep
    push_sweep(30 * 160 + 51, 1'b0);
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    wait_drain(5000);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    push_sweep(19200, 1'b1);
    repeat (3) tick();
    reset_n = 1'b1;
    wait_drain(19300);
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_plot_arbiter.md
Name: vga_plot_arbiter

Overview:
- Owns the VGA adapter write port (x, y, colour, plot) and shares it between one internal screen-clear sweep and NUM_REQ external pixel requesters (snake head, tail erase, food, score).
- Sequences a full-screen clear after reset and on demand, then round-robin arbitrates single-pixel writes using a req/ack handshake.
- Sits between game logic and the VGA adapter and replaces all ad-hoc plot muxing.

Parameters:
- WIDTH, 160, screen width in pixels (x range 0..WIDTH-1)
- HEIGHT, 120, screen height in pixels (y range 0..HEIGHT-1)
- NUM_REQ, 3, number of external pixel requesters (1..8)
- CLEAR_COLOUR, 3'b000, colour written by the clear sweep
- BORDER_COLOUR, 3'b111, border colour (optional feature only)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- clear_req  in  1  single-cycle request to clear the whole screen
- clear_busy  out  1  high while the clear sweep runs
- clear_done  out  1  one-cycle pulse when the sweep completes
- req  in  NUM_REQ  per-requester pixel request
- req_x  in  8*NUM_REQ  packed x; requester i uses bits [8i+7:8i]
- req_y  in  7*NUM_REQ  packed y; requester i uses bits [7i+6:7i]
- req_colour  in  3*NUM_REQ  packed colour
- ack  out  NUM_REQ  one-hot, one-cycle grant/complete pulse
- vga_x  out  8  adapter x
- vga_y  out  7  adapter y
- vga_colour  out  3  adapter colour
- vga_plot  out  1  adapter write enable

Behaviour:
- Decided: one clock (clk); reset_n is asynchronous, active-low.
- Reset values:
  - vga_x, vga_y, vga_colour, vga_plot, ack, clear_done = 0
  - clear_busy = 1
  - state = CLEAR, sweep counters = (0,0)
  - round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
- All outputs are registered.
- States: CLEAR, IDLE, PLOT.
- CLEAR:
  - One pixel per cycle, vga_plot=1, vga_colour=CLEAR_COLOUR.
  - x increments inner (0..WIDTH-1); y increments outer (0..HEIGHT-1).
  - First plotted pixel (0,0); last (WIDTH-1,HEIGHT-1). Exactly WIDTH*HEIGHT (19,200) consecutive plot cycles.
  - The cycle after the last pixel: vga_plot=0, clear_busy=0, clear_done=1 for one cycle, state goes to IDLE.
  - ack stays 0 throughout. External req inputs are held pending, not dropped.
  - clear_req during CLEAR is ignored; the sweep does not restart.
- IDLE (vga_plot=0, ack=0):
  - If clear_req=1: go to CLEAR with counters at (0,0) and clear_busy=1 on the next cycle. clear_req beats any req in the same cycle.
  - Else if any req bit is set: select winner w as the first set bit searching pointer+1, pointer+2, ... modulo NUM_REQ.
  - Register req_x/req_y/req_colour of w into vga_*, set ack[w]=1, set pointer=w, go to PLOT.
- PLOT:
  - vga_plot=1 and ack[w]=1 for exactly this one cycle, then return to IDLE.
  - Throughput is one external pixel per 2 cycles.
  - clear_req arriving in PLOT is latched and serviced in the following IDLE cycle.
- Out of range: if the winner's x >= WIDTH or y >= HEIGHT, ack is still issued but vga_plot stays 0 in PLOT.
- Requester rules:
  - Hold req, x, y and colour stable until ack is sampled high.
  - Deassert req, or present the next pixel, on the same edge ack is sampled.
  - Dropping req before ack is legal: no grant, no plot.
- Reset asserted mid-sweep or mid-PLOT:
  - All outputs return to reset values immediately.
  - The sweep restarts at (0,0) after release.
  - A pending ack is lost; the requester must re-request.
- Counter widths: x 8 bits, y 7 bits. Wrap is explicit at WIDTH-1 and HEIGHT-1, never by overflow.

Optional Feature:
- Macro: VGA_PLOT_ARBITER_BORDER_EN.
- Defined: during CLEAR, pixels with x==0, x==WIDTH-1, y==0 or y==HEIGHT-1 are written with BORDER_COLOUR; all others use CLEAR_COLOUR. Pixel count and timing are unchanged.
- Undefined: every sweep pixel uses CLEAR_COLOUR.

Test Plan:
- Release reset, req=0 -> 19,200 consecutive vga_plot cycles, first (0,0), last (159,119), all colour 0; clear_done pulses once the next cycle and clear_busy falls with it.
- After clear, req=3'b111 held with distinct coordinates, each requester dropping req on its ack -> grant order 0,1,2; plots 2 cycles apart; each ack one cycle, coincident with vga_plot.
- req[1] continuously re-requesting, req[2] held -> grants alternate 1,2,1,2; requester 2 is never starved.
- req[0] with x=160, y=5 -> ack[0] pulses, vga_plot stays 0, no adapter write.
- clear_req and req[0] asserted in the same IDLE cycle -> sweep starts; ack[0] first occurs the cycle after clear_done; clear_req pulsed again mid-sweep -> still exactly 19,200 plots.
- reset_n pulsed low at sweep pixel (50,30) -> outputs zero immediately; after release the sweep restarts at (0,0); with VGA_PLOT_ARBITER_BORDER_EN defined, (0,0) and (159,60) are written colour 7 and (80,60) colour 0.
